shift_unit: RTL and testbench



---
 rtl/shift_unit.sv | 150 +++++++++++++++
 tb/tb_shift_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit.sv
// -----------------------------------------------------------------------------
// shift_unit
//   Iterative shift execution unit for the multicycle MIPS datapath. A start
//   pulse in IDLE latches the operand, operation and shift amount. The unit
//   then shifts one bit position per clock and raises a one-cycle done pulse
//   when data_out holds the final result. The result is held until the next
//   accepted start.
//
// Ports
//   clk       in   1      system clock, rising-edge active
//   reset     in   1      asynchronous, active-high reset
//   start     in   1      request, sampled only while idle
//   op        in   2      00 SLL, 01 SRL, 10 SRA, 11 ROR / pass-through
//   shamt     in   SA_W   shift amount
//   data_in   in   WIDTH  operand to shift
//   data_out  out  WIDTH  shift register contents (final result after done)
//   busy      out  1      high whenever the unit is not idle
//   done      out  1      one-cycle pulse: data_out holds the final result
//
// Configuration macro
//   SHIFT_ROTATE_EN  defined:   op=11 rotates right by shamt.
//                    undefined: op=11 passes data_in straight through and
//                               completes in the cycle after start.
//
// SA_W must equal clog2(WIDTH).
// -----------------------------------------------------------------------------
module shift_unit #(
  parameter int WIDTH = 32,
  parameter int SA_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [SA_W-1:0]  shamt,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t           r_state;
  op_t              r_op;
  logic [WIDTH-1:0] r_sreg;
  logic [SA_W-1:0]  r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_shifted;
  logic             w_pass;
  logic             w_skip_shift;

  // One-position shift of the current register contents.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_shifted = r_sreg;
    case (r_op)
      OP_SLL:  w_shifted = {r_sreg[WIDTH-2:0], 1'b0};
      OP_SRL:  w_shifted = {1'b0, r_sreg[WIDTH-1:1]};
      OP_SRA:  w_shifted = {r_sreg[WIDTH-1], r_sreg[WIDTH-1:1]};
`ifdef SHIFT_ROTATE_EN
      OP_ROR:  w_shifted = {r_sreg[0], r_sreg[WIDTH-1:1]};
`endif
      default: w_shifted = r_sreg;
    endcase
  end

  // Without the rotate option, op=11 is a pass-through that never shifts.
`ifdef SHIFT_ROTATE_EN
  assign w_pass = 1'b0;
`else
  assign w_pass = (op == OP_ROR);
`endif

  assign w_skip_shift = w_pass || (shamt == '0);

  // busy/done are registered alongside the state so they decode exactly as
  // (state != IDLE) and (state == DONE) without any combinational output path.
  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= OP_SLL;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sreg <= data_in;
            r_op   <= op_t'(op);
            r_cnt  <= w_pass ? '0 : shamt;
            r_busy <= 1'b1;
            if (w_skip_shift) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_SHIFT;
            end
          end
        end

        S_SHIFT: begin
          r_sreg <= w_shifted;
          // cnt is at least 1 here, so it cannot underflow.
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == SA_W'(1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end

        S_DONE: begin
          // start is deliberately ignored here; it is not queued.
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out = r_sreg;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_shift_unit.sv
// -----------------------------------------------------------------------------
// tb_shift_unit
//   Self-checking bench for shift_unit. A vector table covers the shift
//   operations; hand-written sequences cover start-while-busy and reset
//   mid-operation. Expected results go into a scoreboard queue when a start
//   is driven; a monitor pops and compares them whenever done is seen.
// -----------------------------------------------------------------------------
module tb_shift_unit;

  localparam int WIDTH = 32;
  localparam int SA_W  = 5;

  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRL = 2'b01;
  localparam logic [1:0] SRA = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  logic             clk;
  logic             reset;
  logic             start;
  logic [1:0]       op;
  logic [SA_W-1:0]  shamt;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic             done;

  shift_unit #(.WIDTH(WIDTH), .SA_W(SA_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .shamt    (shamt),
    .data_in  (data_in),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]       op;
    logic [SA_W-1:0]  shamt;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] exp;
    int               lat;   // edges from the start edge to the done cycle
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               lat;
    int               issue;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [1:0] o, input int s,
                         input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] e,
                         input int l);
    vec_t v;
    v.op    = o;
    v.shamt = SA_W'(s);
    v.din   = d;
    v.exp   = e;
    v.lat   = l;
    vecs.push_back(v);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1'b1, 1'b0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("result", data_out, e.data);
        check("latency", WIDTH'(cyc - e.issue), WIDTH'(e.lat));
      end
    end
  end

  // Drive a start pulse at a falling edge and record the expectation.
  // The next rising edge is the accepting edge, hence issue = cyc + 1.
  task automatic issue(input logic [1:0] o, input logic [SA_W-1:0] s,
                       input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] e,
                       input int l);
    sb_t x;
    @(negedge clk);
    start   = 1'b1;
    op      = o;
    shamt   = s;
    data_in = d;
    x.data  = e;
    x.lat   = l;
    x.issue = cyc + 1;
    sb.push_back(x);
    @(negedge clk);
    start   = 1'b0;
    data_in = '0;
  endtask

  // Called at the first falling edge after the accepting edge. Counts busy
  // cycles up to and including the done cycle, with a bounded wait.
  task automatic wait_done(input string name, input int exp_lat);
    int b;
    bit seen;
    b    = 0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (busy) b++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, "_done_seen"}, WIDTH'(seen), WIDTH'(1));
    if (!seen) sb.delete();
    check({name, "_busy_cycles"}, WIDTH'(b), WIDTH'(exp_lat + 1));
    @(negedge clk);
    check({name, "_idle_after"}, WIDTH'(busy), WIDTH'(0));
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    op      = SLL;
    shamt   = '0;
    data_in = '0;

    // Vector table
    add_vec(SLL,  4, 32'h0000_0001, 32'h0000_0010,  4);
    add_vec(SRA, 31, 32'h8000_0000, 32'hFFFF_FFFF, 31);
    add_vec(SRL, 31, 32'h8000_0000, 32'h0000_0001, 31);
    add_vec(SLL,  0, 32'hDEAD_BEEF, 32'hDEAD_BEEF,  0);
    add_vec(SRL,  8, 32'hF0F0_F0F0, 32'h00F0_F0F0,  8);
    add_vec(SRA, 16, 32'h7FFF_0000, 32'h0000_7FFF, 16);
    add_vec(SRA,  4, 32'hF000_0000, 32'hFF00_0000,  4);
    add_vec(SLL, 31, 32'h1234_5679, 32'h8000_0000, 31);
    add_vec(SRA,  0, 32'hDEAD_BEEF, 32'hDEAD_BEEF,  0);
    add_vec(SRL,  1, 32'h0000_0003, 32'h0000_0001,  1);
`ifdef SHIFT_ROTATE_EN
    add_vec(ROR,  1, 32'h0000_0001, 32'h8000_0000,  1);
    add_vec(ROR,  8, 32'h1234_5678, 32'h7812_3456,  8);
    add_vec(ROR, 31, 32'h0000_0001, 32'h0000_0002, 31);
`else
    add_vec(ROR,  1, 32'h0000_0001, 32'h0000_0001,  0);
    add_vec(ROR,  8, 32'h1234_5678, 32'h1234_5678,  0);
    add_vec(ROR, 31, 32'h0000_0001, 32'h0000_0001,  0);
`endif

    // Reset state, checked while reset is still asserted
    #12;
    check("reset_data_out", data_out, '0);
    check("reset_busy", WIDTH'(busy), WIDTH'(0));
    check("reset_done", WIDTH'(done), WIDTH'(0));
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].shamt, vecs[i].din, vecs[i].exp, vecs[i].lat);
      wait_done($sformatf("vec%0d", i), vecs[i].lat);
      check($sformatf("vec%0d_hold", i), data_out, vecs[i].exp);
    end

    // start during SHIFT and during DONE is ignored
    begin
      bit seen;
      issue(SLL, 5'd4, 32'h0000_0001, 32'h0000_0010, 4);
      @(negedge clk);
      start = 1'b1; op = SRL; shamt = 5'd3; data_in = 32'hFFFF_FFFF;
      @(negedge clk);
      start = 1'b0;
      seen  = 1'b0;
      for (int k = 0; k < 40; k++) begin
        if (done) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check("busy_start_done_seen", WIDTH'(seen), WIDTH'(1));
      if (!seen) sb.delete();
      // Pulse start throughout the DONE cycle
      start = 1'b1; op = SRA; shamt = 5'd2; data_in = 32'h8000_0000;
      @(negedge clk);
      start = 1'b0;
      check("done_start_ignored_busy", WIDTH'(busy), WIDTH'(0));
      repeat (6) @(negedge clk);
      check("busy_start_result_kept", data_out, 32'h0000_0010);
      check("busy_start_still_idle", WIDTH'(busy), WIDTH'(0));
    end

    // Reset asserted at shift 3 of an SLL by 10
    issue(SLL, 5'd10, 32'h0000_0001, 32'h0000_0400, 10);
    repeat (3) @(negedge clk);
    check("pre_reset_shift3", data_out, 32'h0000_0008);
    #1 reset = 1'b1;
    #1;
    check("midreset_data_out", data_out, '0);
    check("midreset_busy", WIDTH'(busy), WIDTH'(0));
    check("midreset_done", WIDTH'(done), WIDTH'(0));
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("post_reset_idle", WIDTH'(busy), WIDTH'(0));
    check("post_reset_data", data_out, '0);

    issue(SLL, 5'd2, 32'h0000_0003, 32'h0000_000C, 2);
    wait_done("after_reset", 2);
    check("after_reset_hold", data_out, 32'h0000_000C);

    check("scoreboard_empty", WIDTH'(sb.size()), WIDTH'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
